// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard and branch-flush control beside the ID stage.
// Tracks loads with multi-cycle latency in a per-register scoreboard and keeps saturating stall/flush counters.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ID_EX_MemRead,
  input  logic [ADDR_W-1:0]  ID_EX_rd_addr,
  input  logic [ADDR_W-1:0]  IF_ID_rs1_addr,
  input  logic [ADDR_W-1:0]  IF_ID_rs2_addr,
  input  logic               IF_ID_rs1_used,
  input  logic               IF_ID_rs2_used,
  input  logic               EX_MEM_Branch,
  input  logic               EX_MEM_zero,
  input  logic               mem_busy,
  input  logic               cnt_clear,
  output logic               stall,
  output logic               load_use_stall,
  output logic               flush_IF_ID,
  output logic               flush_ID_EX,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count
);

  localparam int SB_W = ($clog2(LOAD_LAT) > 1) ? $clog2(LOAD_LAT) : 1;
  localparam logic [SB_W-1:0] SB_INIT = SB_W'(LOAD_LAT - 1);
  localparam int ADDR_SPACE = 2 ** ADDR_W;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    sat_inc = (c == {COUNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  logic [SB_W-1:0]       sb [1:NUM_REGS-1];
  logic [ADDR_SPACE-1:0] pend_vec;
  logic                  taken;
  logic                  dep_rs1;
  logic                  dep_rs2;
  logic                  hit;
  logic                  flush_int;
  logic                  lu_int;
  logic                  stall_int;
  logic                  load_set;

  // Pending flags are widened to the full address space so out-of-range sources read as idle.
  always_comb begin
    pend_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      pend_vec[r] = |sb[r];
    end
  end

  assign taken   = EX_MEM_Branch & EX_MEM_zero;
  assign dep_rs1 = (IF_ID_rs1_addr != '0) &
                   ((ID_EX_MemRead & (ID_EX_rd_addr == IF_ID_rs1_addr)) | pend_vec[IF_ID_rs1_addr]);
  assign dep_rs2 = (IF_ID_rs2_addr != '0) &
                   ((ID_EX_MemRead & (ID_EX_rd_addr == IF_ID_rs2_addr)) | pend_vec[IF_ID_rs2_addr]);
  assign hit     = (IF_ID_rs1_used & dep_rs1) | (IF_ID_rs2_used & dep_rs2);

  // A flush discards the dependent instruction, so it wins over the dependency stall.
  assign flush_int = rst_n & taken & ~mem_busy;
  assign lu_int    = rst_n & hit & ~flush_int;
  assign stall_int = rst_n & (mem_busy | lu_int);

  assign flush_IF_ID    = flush_int;
  assign flush_ID_EX    = flush_int;
  assign load_use_stall = lu_int;
  assign stall          = stall_int;

  // Wrong-path loads under a taken branch are never recorded; single-cycle loads need no entry.
  assign load_set = ID_EX_MemRead & ~taken & (ID_EX_rd_addr != '0) & (LOAD_LAT > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        sb[r] <= '0;
      end
    end else if (!mem_busy) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (load_set && (ID_EX_rd_addr == ADDR_W'(r))) begin
          sb[r] <= SB_INIT;
        end else if (sb[r] != '0) begin
          sb[r] <= sb[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (cnt_clear) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_int) begin
        stall_count <= sat_inc(stall_count);
      end
      if (flush_int) begin
        flush_count <= sat_inc(flush_count);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: two instances (LOAD_LAT=1/COUNT_W=32 and LOAD_LAT=3/COUNT_W=4)
// compared against a ready-time reference model under directed and random stimulus.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ID_EX_MemRead = 1'b0;
  logic [4:0] ID_EX_rd_addr = '0;
  logic [4:0] IF_ID_rs1_addr = '0;
  logic [4:0] IF_ID_rs2_addr = '0;
  logic       IF_ID_rs1_used = 1'b0;
  logic       IF_ID_rs2_used = 1'b0;
  logic       EX_MEM_Branch = 1'b0;
  logic       EX_MEM_zero = 1'b0;
  logic       mem_busy = 1'b0;
  logic       cnt_clear = 1'b0;

  logic        stall_a, lus_a, fif_a, fie_a;
  logic [31:0] sc_a, fc_a;
  logic        stall_b, lus_b, fif_b, fie_b;
  logic [3:0]  sc_b, fc_b;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.NUM_REGS(32), .ADDR_W(5), .LOAD_LAT(1), .COUNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd_addr(ID_EX_rd_addr),
    .IF_ID_rs1_addr(IF_ID_rs1_addr), .IF_ID_rs2_addr(IF_ID_rs2_addr),
    .IF_ID_rs1_used(IF_ID_rs1_used), .IF_ID_rs2_used(IF_ID_rs2_used),
    .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_zero(EX_MEM_zero),
    .mem_busy(mem_busy), .cnt_clear(cnt_clear),
    .stall(stall_a), .load_use_stall(lus_a),
    .flush_IF_ID(fif_a), .flush_ID_EX(fie_a),
    .stall_count(sc_a), .flush_count(fc_a)
  );

  hazard_scoreboard_unit #(.NUM_REGS(32), .ADDR_W(5), .LOAD_LAT(3), .COUNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd_addr(ID_EX_rd_addr),
    .IF_ID_rs1_addr(IF_ID_rs1_addr), .IF_ID_rs2_addr(IF_ID_rs2_addr),
    .IF_ID_rs1_used(IF_ID_rs1_used), .IF_ID_rs2_used(IF_ID_rs2_used),
    .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_zero(EX_MEM_zero),
    .mem_busy(mem_busy), .cnt_clear(cnt_clear),
    .stall(stall_b), .load_use_stall(lus_b),
    .flush_IF_ID(fif_b), .flush_ID_EX(fie_b),
    .stall_count(sc_b), .flush_count(fc_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a register is busy until the count of unfrozen edges reaches its ready time.
  int     lat [2]  = '{1, 3};
  longint cmax [2] = '{64'hFFFF_FFFF, 64'd15};
  longint ready [2][32];
  longint tick [2];
  longint scnt [2];
  longint fcnt [2];
  bit     m_stall [2];
  bit     m_lus [2];
  bit     m_fl [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit mdep(input int d, input logic [4:0] r);
    return (r != 0) && ((ID_EX_MemRead && ID_EX_rd_addr == r) || (tick[d] < ready[d][r]));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 32; r++) ready[d][r] = 0;
      scnt[d] = 0;
      fcnt[d] = 0;
    end
  endtask

  task automatic settle();
    bit tk, hit;
    #3;
    tk = EX_MEM_Branch && EX_MEM_zero;
    for (int d = 0; d < 2; d++) begin
      hit = (IF_ID_rs1_used && mdep(d, IF_ID_rs1_addr)) || (IF_ID_rs2_used && mdep(d, IF_ID_rs2_addr));
      m_fl[d]    = tk && !mem_busy;
      m_lus[d]   = hit && !m_fl[d];
      m_stall[d] = mem_busy || m_lus[d];
    end
    check("a.stall", stall_a, m_stall[0]);
    check("a.load_use_stall", lus_a, m_lus[0]);
    check("a.flush_IF_ID", fif_a, m_fl[0]);
    check("a.flush_ID_EX", fie_a, m_fl[0]);
    check("a.stall_count", sc_a, scnt[0]);
    check("a.flush_count", fc_a, fcnt[0]);
    check("b.stall", stall_b, m_stall[1]);
    check("b.load_use_stall", lus_b, m_lus[1]);
    check("b.flush_IF_ID", fif_b, m_fl[1]);
    check("b.flush_ID_EX", fie_b, m_fl[1]);
    check("b.stall_count", sc_b, scnt[1]);
    check("b.flush_count", fc_b, fcnt[1]);
  endtask

  task automatic edge_step();
    bit tk;
    @(posedge clk);
    tk = EX_MEM_Branch && EX_MEM_zero;
    for (int d = 0; d < 2; d++) begin
      if (cnt_clear) begin
        scnt[d] = 0;
        fcnt[d] = 0;
      end else begin
        if (m_stall[d] && scnt[d] < cmax[d]) scnt[d]++;
        if (m_fl[d] && fcnt[d] < cmax[d]) fcnt[d]++;
      end
      if (!mem_busy) begin
        if (ID_EX_MemRead && ID_EX_rd_addr != 0 && !tk) ready[d][ID_EX_rd_addr] = tick[d] + lat[d];
        tick[d]++;
      end
    end
    #1;
  endtask

  task automatic step();
    settle();
    edge_step();
  endtask

  task automatic set_in(input bit mr, input int rd, input int rs1, input bit u1, input int rs2, input bit u2,
                        input bit br, input bit z, input bit busy);
    ID_EX_MemRead  = mr;
    ID_EX_rd_addr  = 5'(rd);
    IF_ID_rs1_addr = 5'(rs1);
    IF_ID_rs1_used = u1;
    IF_ID_rs2_addr = 5'(rs2);
    IF_ID_rs2_used = u2;
    EX_MEM_Branch  = br;
    EX_MEM_zero    = z;
    mem_busy       = busy;
  endtask

  // Assert reset mid-cycle with live inputs; outputs must drop at once.
  task automatic reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.a.stall", stall_a, 1'b0);
    check("rst.a.load_use_stall", lus_a, 1'b0);
    check("rst.a.flush", {fif_a, fie_a}, 2'b00);
    check("rst.a.counts", {sc_a, fc_a}, 64'd0);
    check("rst.b.stall", stall_b, 1'b0);
    check("rst.b.load_use_stall", lus_b, 1'b0);
    check("rst.b.flush", {fif_b, fie_b}, 2'b00);
    check("rst.b.counts", {sc_b, fc_b}, 8'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    tick[0] = 0;
    tick[1] = 0;
    // Reset state with hazard-looking inputs held
    set_in(1, 5, 5, 1, 0, 0, 1, 1, 1);
    #2;
    check("init.stall", {stall_a, stall_b}, 2'b00);
    check("init.flush", {fif_a, fif_b, fie_a, fie_b}, 4'b0000);
    check("init.counts", {sc_a, fc_a, sc_b, fc_b}, 72'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Classic load-use: LOAD_LAT=1 stalls one cycle, LOAD_LAT=3 stalls three
    set_in(1, 5, 5, 1, 0, 0, 0, 0, 0);
    settle();
    check("plan.lat1.stall", {stall_a, lus_a}, 2'b11);
    edge_step();
    set_in(0, 0, 5, 1, 0, 0, 0, 0, 0);
    settle();
    check("plan.lat1.released", stall_a, 1'b0);
    check("plan.lat1.count", sc_a, 32'd1);
    check("plan.lat3.held", stall_b, 1'b1);
    edge_step();
    settle();
    check("plan.lat3.held2", stall_b, 1'b1);
    edge_step();
    settle();
    check("plan.lat3.released", stall_b, 1'b0);
    edge_step();

    // Load to x7 on LAT=3, dependent held in ID through cycles 0..3
    set_in(1, 7, 7, 1, 0, 0, 0, 0, 0);
    step();
    set_in(0, 0, 7, 1, 0, 0, 0, 0, 0);
    repeat (3) step();

    // x0 destination and unused source never stall
    set_in(1, 0, 0, 1, 0, 1, 0, 0, 0);
    step();
    set_in(1, 5, 0, 0, 5, 0, 0, 0, 0);
    settle();
    check("plan.unused.nostall", {stall_a, stall_b}, 2'b00);
    edge_step();
    set_in(0, 0, 5, 1, 5, 1, 0, 0, 0);
    repeat (3) step();

    // Taken branch over a wrong-path load: flush wins, nothing recorded
    set_in(1, 9, 9, 1, 0, 0, 1, 1, 0);
    settle();
    check("plan.flush.out", {fif_a, fie_a, stall_a, fif_b, fie_b, stall_b}, 6'b110110);
    edge_step();
    set_in(0, 0, 9, 1, 0, 0, 0, 0, 0);
    settle();
    check("plan.flush.sb9", stall_b, 1'b0);
    edge_step();

    // mem_busy freeze after a load to x3, taken branch held off until busy drops
    set_in(1, 3, 0, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 0, 1, 1, 2, 1, 0, 0, 1);
    repeat (2) step();
    set_in(0, 0, 1, 1, 2, 1, 1, 1, 1);
    repeat (2) step();
    set_in(0, 0, 3, 1, 0, 0, 1, 1, 0);
    step();
    set_in(0, 0, 3, 1, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Reset mid-stall with a pending x4 entry
    set_in(1, 4, 0, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 0, 4, 1, 0, 0, 0, 0, 0);
    settle();
    reset_mid();
    step();

    // Saturate the 4-bit counter, then clear
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (18) step();
    check("plan.sat", sc_b, 4'd15);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 9) < 4,
             ($urandom_range(0, 9) < 8) ? $urandom_range(0, 7) : $urandom_range(0, 31),
             $urandom_range(0, 7), $urandom_range(0, 9) < 7,
             $urandom_range(0, 7), $urandom_range(0, 9) < 6,
             $urandom_range(0, 9) < 2, $urandom_range(0, 1),
             $urandom_range(0, 99) < 15);
      cnt_clear = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 2) begin
        settle();
        reset_mid();
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised load-use hazard and control-flush unit for the 5-stage RISC-V pipeline. It generalises the single-cycle load-use check to loads with a configurable latency by keeping a per-register pending scoreboard. It honours per-source "used" flags and a memory-busy freeze, and keeps saturating stall/flush performance counters. It sits beside the ID stage and drives PC/IF_ID write-enable and the IF_ID/ID_EX flush controls.

Parameters:
NUM_REGS, 32, architectural register count; x0 is never tracked.
ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
LOAD_LAT, 1, cycles after EX until load data is forwardable to EX; legal range 1..8. LOAD_LAT=1 reproduces the classic single-bubble load-use stall.
COUNT_W, 32, performance counter width.

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
ID_EX_MemRead  input  1  instruction in ID_EX is a load
ID_EX_rd_addr  input  ADDR_W  destination of the ID_EX instruction
IF_ID_rs1_addr  input  ADDR_W  rs1 of the instruction in ID
IF_ID_rs2_addr  input  ADDR_W  rs2 of the instruction in ID
IF_ID_rs1_used  input  1  ID instruction reads rs1
IF_ID_rs2_used  input  1  ID instruction reads rs2
EX_MEM_Branch  input  1  EX_MEM holds a branch
EX_MEM_zero  input  1  branch condition true
mem_busy  input  1  data memory not ready; whole pipeline frozen
cnt_clear  input  1  synchronous clear of performance counters
stall  output  1  hold PC and IF_ID, insert bubble into ID_EX
load_use_stall  output  1  stall is caused by a register dependency, not mem_busy
flush_IF_ID  output  1  squash the IF_ID instruction
flush_ID_EX  output  1  squash the ID_EX instruction
stall_count  output  COUNT_W  cycles with stall=1, saturating
flush_count  output  COUNT_W  taken-branch flush events, saturating

Behaviour:
- Scoreboard: NUM_REGS-1 counters, each of width max(1, clog2(LOAD_LAT)), plus a notional x0 entry that is always 0. All counters are 0 on reset.
- taken = EX_MEM_Branch & EX_MEM_zero.
- dep(r) = (r != 0) & [ (ID_EX_MemRead & ID_EX_rd_addr == r) | (sb[r] != 0) ].
- hit = (IF_ID_rs1_used & dep(rs1)) | (IF_ID_rs2_used & dep(rs2)).
- Combinational outputs, evaluated while rst_n is high:
  - flush_IF_ID = flush_ID_EX = taken & ~mem_busy.
  - load_use_stall = hit & ~flush_IF_ID.
  - stall = mem_busy | load_use_stall.
  - Flush dominates a dependency stall, because the dependent instruction is discarded.
- Clocked update, rising edge, only when mem_busy=0 (all counters hold while mem_busy=1):
  - Each nonzero sb[r] decrements by 1.
  - If ID_EX_MemRead & ID_EX_rd_addr != 0 & ~taken & LOAD_LAT > 1, then sb[ID_EX_rd_addr] <= LOAD_LAT-1. This overrides the decrement of the same entry.
  - A load in ID_EX during a taken flush is wrong-path and is never recorded.
  - Older loads past EX are never cleared by a flush.
- Performance counters:
  - stall_count increments on every edge with stall=1, including mem_busy cycles.
  - flush_count increments on every edge with flush_IF_ID=1.
  - Both saturate at all-ones.
  - cnt_clear=1 zeroes both and takes priority over increment.
- Reset: asserting rst_n low immediately clears the scoreboard and both counters, and forces stall, load_use_stall, flush_IF_ID and flush_ID_EX to 0 regardless of inputs. First valid evaluation is after rst_n deasserts. Reset mid-stall simply drops the stall.
- Latency: all hazard outputs are 0-cycle combinational from inputs plus current scoreboard state. Scoreboard effects appear one edge after load issue.
- A rd address >= NUM_REGS is ignored (no entry is set).
- Use flags gate dependency detection: a source with used=0 never stalls, even when its address matches.

Test Plan:
- LOAD_LAT=1: ID_EX load with rd=5, ID reads rs1=5 (used) -> stall=1, load_use_stall=1 for 1 cycle. Next cycle with a non-load in ID_EX -> stall=0. stall_count=1.
- LOAD_LAT=3: load rd=7 issues at cycle 0, dependent instruction held in ID -> stall high in cycles 0,1,2 and low in cycle 3. sb[7] sequence is 2,1,0.
- Load with rd=0, or rs2=5 with rs2_used=0 against a load to x5 -> stall=0. No scoreboard entry set.
- Taken branch (Branch=1, zero=1) while ID_EX holds a load to x9 and ID reads x9 -> flush_IF_ID=flush_ID_EX=1, stall=0, sb[9] stays 0, flush_count +1.
- LOAD_LAT=3: mem_busy=1 for 4 cycles right after a load to x3 -> stall=1 throughout, load_use_stall=0 while no dependent instruction in ID, sb[3] holds at 2. Simultaneous taken branch gives no flush until mem_busy drops.
- Pull rst_n low mid-stall (sb[4]=2) -> outputs 0 immediately. After release, sb cleared and counters 0. Separately: preload stall_count to all-ones with COUNT_W=4 -> stays 15; cnt_clear=1 -> 0.
